// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetch FSM with redirect.
// Optional delivered-instruction counter enabled by IFU_FETCH_COUNT_EN.
module instruction_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
`ifdef IFU_FETCH_COUNT_EN
    output logic [15:0] fetch_count,
`endif
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_FULL,
        S_DROP
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        hs;

    assign tgt = branch_target & 32'hFFFF_FFFC;
    assign hs  = instr_valid & instr_ready;

    // A request goes out only in FETCH, never during reset or a redirect
    assign imem_req  = (state == S_FETCH) & ~branch_taken & ~rst;
    assign imem_addr = pc;

    // Fetch FSM: issue, wait for data, hold for decoder, or drop stale data
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= 32'h0;
            instruction <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (branch_taken) begin
                        pc <= tgt;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (branch_taken) begin
                        pc    <= tgt;
                        state <= imem_rvalid ? S_FETCH : S_DROP;
                    end else if (imem_rvalid) begin
                        instruction <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (branch_taken || hs) begin
                        instr_valid <= 1'b0;
                        pc          <= branch_taken ? tgt : pc + 32'd4;
                        state       <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (branch_taken) begin
                        pc <= tgt;
                    end
                    if (imem_rvalid) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef IFU_FETCH_COUNT_EN
    // Count words handed to the decoder, including one accepted during a redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 16'h0;
        end else if (state == S_FULL && hs) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with a variable-latency memory.
// Counter checks are compiled in when IFU_FETCH_COUNT_EN is defined.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
`ifdef IFU_FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_rvalid   (imem_rvalid),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
`ifdef IFU_FETCH_COUNT_EN
        .fetch_count   (fetch_count),
`endif
        .instr_ready   (instr_ready)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_pc;
    int          hs_count;
    int          lat;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    int          cyc;
    int          last_req;
    logic        gap_on;
    logic        saw_req;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h01013B06;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // One clock cycle: memory response, request/handshake bookkeeping, edge
    task automatic tick();
        logic [63:0] e;
        saw_req = 1'b0;
        if (!rst && pend && cnt == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem(paddr);
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEADBEEF;
            if (pend) cnt--;
        end
        #1;
        if (rst) begin
            chk("rst_req_low", {31'b0, imem_req}, 32'h0);
            pend     = 1'b0;
            sb.delete();
            exp_pc   = 32'h0;
            hs_count = 0;
        end else begin
            if (imem_req) begin
                saw_req = 1'b1;
                chk("req_addr", imem_addr, exp_pc);
                chk("one_outstanding", {31'b0, pend}, 32'h0);
                if (gap_on && last_req >= 0)
                    chk("req_gap", cyc - last_req, 3);
                last_req = cyc;
                pend     = 1'b1;
                cnt      = lat;
                paddr    = imem_addr;
                sb.push_back({imem_addr, mem(imem_addr)});
            end
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_depth", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("instr", instruction, e[31:0]);
                    chk("instr_pc", instr_pc, e[63:32]);
                    exp_pc = e[63:32] + 32'd4;
                end
                hs_count++;
            end
            if (branch_taken) begin
                exp_pc = branch_target & 32'hFFFF_FFFC;
                sb.delete();
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        chk("wait_valid", {31'b0, instr_valid}, 32'h1);
    endtask

    task automatic wait_req();
        int n = 0;
        saw_req = 1'b0;
        while (!saw_req && n < 20) begin
            tick();
            n++;
        end
        chk("wait_req", {31'b0, saw_req}, 32'h1);
    endtask

    logic [31:0] ins0, pc0;
    int          hs0;

    initial begin
        rst = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        instr_ready = 1'b0;
        exp_pc = 32'h0;
        hs_count = 0;
        lat = 1;
        pend = 1'b0;
        cnt = 0;
        paddr = 32'h0;
        cyc = 0;
        last_req = -1;
        gap_on = 1'b0;
        @(negedge clk);

        // reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);

        // streaming, 1-cycle memory
        instr_ready = 1'b1;
        gap_on = 1'b1;
        repeat (9) tick();
        gap_on = 1'b0;
        chk("stream_hs", hs_count, 3);
`ifdef IFU_FETCH_COUNT_EN
        chk("stream_count", {16'b0, fetch_count}, 32'd3);
`endif

        // backpressure
        instr_ready = 1'b0;
        wait_valid();
        ins0 = instruction;
        pc0 = instr_pc;
        for (int i = 0; i < 5; i++) begin
            chk("bp_req", {31'b0, imem_req}, 32'h0);
            tick();
            chk("bp_instr", instruction, ins0);
            chk("bp_pc", instr_pc, pc0);
        end
        instr_ready = 1'b1;
        tick();
        chk("bp_next_req", {31'b0, imem_req}, 32'h1);
        chk("bp_next_addr", imem_addr, pc0 + 32'd4);

        // redirect in WAIT before response
        lat = 3;
        wait_req();
        branch_taken = 1'b1;
        branch_target = 32'h103;
        tick();
        branch_taken = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) break;
            chk("redir_valid", {31'b0, instr_valid}, 32'h0);
            tick();
        end
        chk("redir_addr", imem_addr, 32'h100);
        lat = 1;
        tick();
        wait_valid();
        chk("redir_pc", instr_pc, 32'h100);
        tick();

        // redirect in FETCH suppresses request; wrap past top of memory
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        #1;
        chk("br_fetch_req", {31'b0, imem_req}, 32'h0);
        tick();
        branch_taken = 1'b0;
        chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        wait_valid();
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_req", {31'b0, imem_req}, 32'h1);
        chk("wrap_addr", imem_addr, 32'h0);

        // redirect in WAIT with same-cycle response
        lat = 2;
        tick();
        tick();
        branch_taken = 1'b1;
        branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        chk("same_valid", {31'b0, instr_valid}, 32'h0);
        chk("same_addr", imem_addr, 32'h200);
        tick();

        // redirect in FULL together with handshake
        wait_valid();
        hs0 = hs_count;
        branch_taken = 1'b1;
        branch_target = 32'h300;
        tick();
        branch_taken = 1'b0;
        chk("full_hs", hs_count, hs0 + 1);
        chk("full_valid", {31'b0, instr_valid}, 32'h0);
        chk("full_addr", imem_addr, 32'h300);
`ifdef IFU_FETCH_COUNT_EN
        chk("full_count", {16'b0, fetch_count}, hs_count);
`endif

        // reset with a request in flight
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'h1);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
        lat = 1;
        tick();
        wait_valid();
        chk("mid_rst_pc", instr_pc, 32'h0);
        tick();

`ifdef IFU_FETCH_COUNT_EN
        // counter: three handshakes then reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        while (hs_count < 3 && cyc < 2000) tick();
        chk("cnt_three", {16'b0, fetch_count}, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("cnt_zero", {16'b0, fetch_count}, 32'd0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
